fft_out_reorder: RTL and testbench

//  Receive side of the FFT output interface: buffers the 4-lane bit-reversed frames from topfft and re-emits them in per-lane natural order.

---
 rtl/fft_pkg.sv | 24 ++
 rtl/reorder_bank.sv | 24 ++
 rtl/fft_out_reorder.sv | 168 ++++++++++++++++
 tb/tb_fft_out_reorder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT output reorder buffer.
package fft_pkg;
  localparam int NBITS_OUT = 19;
  localparam int FFT_N     = 128;
  localparam int LOG2N     = $clog2(FFT_N);
  localparam int LANES     = 4;

  typedef logic [2*NBITS_OUT-1:0] word_t;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_LOAD   = 2'd1,
    RD_STREAM = 2'd2
  } rdState_t;

  // Reverse the low 'width' bits of value; upper bits come back zero.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++)
      if (i < width) r[i] = value[width-1-i];
    return r;
  endfunction
endpackage

// File: rtl/reorder_bank.sv
// One sub-bank of the ping-pong frame store: 1W1R RAM with a registered read port.
module reorder_bank #(
  parameter int W  = 38,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [W-1:0]  wd,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [W-1:0]  rd
);
  logic [W-1:0] mem [2**AW];

  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;

  // Read register only loads on re, so it doubles as the output hold register.
  always_ff @(posedge clk or negedge rst)
    if (!rst)    rd <= '0;
    else if (re) rd <= mem[ra];
endmodule

// File: rtl/fft_out_reorder.sv
// Reorders 4-lane bit-reversed FFT frames into per-lane natural order via a ping-pong store.
// Optional REORDER_OVF_CNT_EN adds a saturating dropped-frame counter port ovf_cnt.
module fft_out_reorder import fft_pkg::*; #(
  parameter int NBITS_out = NBITS_OUT,
  parameter int N         = FFT_N
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2*NBITS_out-1:0] fftIn0_up,
  input  logic [2*NBITS_out-1:0] fftIn0_down,
  input  logic [2*NBITS_out-1:0] fftIn1_up,
  input  logic [2*NBITS_out-1:0] fftIn1_down,
  input  logic                   in_valid,
  input  logic                   in_sof,
  output logic [2*NBITS_out-1:0] fftOut0_up,
  output logic [2*NBITS_out-1:0] fftOut0_down,
  output logic [2*NBITS_out-1:0] fftOut1_up,
  output logic [2*NBITS_out-1:0] fftOut1_down,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_sof,
  output logic                   out_eof,
  output logic                   ovf,
  output logic                   sync_err
`ifdef REORDER_OVF_CNT_EN
  , output logic [15:0]          ovf_cnt
`endif
);
  localparam int W  = 2*NBITS_out;
  localparam int LG = $clog2(N);
  localparam int CW = LG-2;
  localparam int AW = CW+1;
  localparam logic [CW-1:0] LAST = CW'(N/4-1);

  logic [LANES-1:0][W-1:0] inLane, outLane;

  assign inLane       = {fftIn1_down, fftIn1_up, fftIn0_down, fftIn0_up};
  assign fftOut0_up   = outLane[0];
  assign fftOut0_down = outLane[1];
  assign fftOut1_up   = outLane[2];
  assign fftOut1_down = outLane[3];

  // write side
  logic          wrBank, wrActive;
  logic [CW-1:0] wrCnt, wrBeat;
  logic [1:0]    bankFull, setFull, clrFull, fullNow;
  logic          startOk, contBeat, wrEn, wrDone, dropNow, syncNow;
  logic [31:0]   wrRev;
  logic [AW-1:0] wrAddr;

  assign dropNow  = in_valid & in_sof & bankFull[wrBank];
  assign syncNow  = in_valid & in_sof & wrActive;
  assign startOk  = in_valid & in_sof & ~bankFull[wrBank];
  assign contBeat = in_valid & ~in_sof & wrActive;
  assign wrEn     = startOk | contBeat;
  assign wrBeat   = in_sof ? '0 : wrCnt;
  assign wrDone   = contBeat & (wrCnt == LAST);
  assign setFull  = wrDone ? (2'b01 << wrBank) : 2'b00;
  assign fullNow  = bankFull | setFull;
  // Address bits of bin bitrev(4c+L) below the sub-bank select are bitrev(c).
  assign wrRev    = bitrev(32'(wrBeat), CW);
  assign wrAddr   = {wrBank, wrRev[CW-1:0]};

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wrBank   <= 1'b0;
      wrActive <= 1'b0;
      wrCnt    <= '0;
      bankFull <= 2'b00;
      ovf      <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      ovf      <= dropNow;
      sync_err <= syncNow;
      bankFull <= fullNow & ~clrFull;
      if (startOk) begin
        wrActive <= 1'b1;
        wrCnt    <= CW'(1);
      end else if (dropNow) begin
        wrActive <= 1'b0;
        wrCnt    <= '0;
      end else if (contBeat) begin
        if (wrDone) begin
          wrActive <= 1'b0;
          wrCnt    <= '0;
          wrBank   <= ~wrBank;
        end else begin
          wrCnt <= wrCnt + 1'b1;
        end
      end
    end

  // read side
  rdState_t      state, stateNxt;
  logic          rdBank, rdEn, accept, rdLast;
  logic [CW-1:0] rdCnt, rdAddrCnt;
  logic [AW-1:0] rdAddr;

  assign accept = (state == RD_STREAM) & out_ready;
  assign rdLast = (rdCnt == LAST);
  assign rdAddr = {rdBank, rdAddrCnt};

  always_comb begin
    stateNxt  = state;
    rdEn      = 1'b0;
    rdAddrCnt = '0;
    clrFull   = 2'b00;
    case (state)
      RD_IDLE: if (bankFull[rdBank]) stateNxt = RD_LOAD;
      RD_LOAD: begin
        rdEn     = 1'b1;
        stateNxt = RD_STREAM;
      end
      RD_STREAM: if (accept) begin
        if (rdLast) begin
          clrFull  = 2'b01 << rdBank;
          // fullNow catches a frame completing in this very cycle
          stateNxt = fullNow[~rdBank] ? RD_LOAD : RD_IDLE;
        end else begin
          rdEn      = 1'b1;
          rdAddrCnt = rdCnt + 1'b1;
        end
      end
      default: stateNxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state  <= RD_IDLE;
      rdBank <= 1'b0;
      rdCnt  <= '0;
    end else begin
      state <= stateNxt;
      if (accept) begin
        if (rdLast) begin
          rdCnt  <= '0;
          rdBank <= ~rdBank;
        end else begin
          rdCnt <= rdCnt + 1'b1;
        end
      end
    end

  assign out_valid = (state == RD_STREAM);
  assign out_sof   = out_valid & (rdCnt == '0);
  assign out_eof   = out_valid & rdLast;

  for (genvar m = 0; m < LANES; m++) begin : gBank
    localparam logic [31:0] SRC = bitrev(32'(m), 2);
    reorder_bank #(.W(W), .AW(AW)) uBank (
      .clk (clk),
      .rst (rst),
      .we  (wrEn),
      .wa  (wrAddr),
      .wd  (inLane[SRC[1:0]]),
      .re  (rdEn),
      .ra  (rdAddr),
      .rd  (outLane[m])
    );
  end

`ifdef REORDER_OVF_CNT_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) ovf_cnt <= '0;
    else if (dropNow && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_fft_out_reorder.sv
// Scenario-table bench for fft_out_reorder with a scoreboard of expected output beats.
module tb_fft_out_reorder;
  localparam int NB  = 19;
  localparam int N   = 128;
  localparam int NB4 = N/4;
  localparam int W   = 2*NB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0] in0u = '0, in0d = '0, in1u = '0, in1d = '0;
  logic [W-1:0] o0u, o0d, o1u, o1d;
  logic in_valid = 1'b0, in_sof = 1'b0, out_ready = 1'b1;
  logic out_valid, out_sof, out_eof, ovf, sync_err;
`ifdef REORDER_OVF_CNT_EN
  logic [15:0] ovf_cnt;
`endif

  fft_out_reorder #(.NBITS_out(NB), .N(N)) dut (
    .clk(clk), .rst(rst),
    .fftIn0_up(in0u), .fftIn0_down(in0d), .fftIn1_up(in1u), .fftIn1_down(in1d),
    .in_valid(in_valid), .in_sof(in_sof),
    .fftOut0_up(o0u), .fftOut0_down(o0d), .fftOut1_up(o1u), .fftOut1_down(o1d),
    .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof), .out_eof(out_eof),
    .ovf(ovf), .sync_err(sync_err)
`ifdef REORDER_OVF_CNT_EN
    , .ovf_cnt(ovf_cnt)
`endif
  );

  typedef struct {
    logic [3:0][W-1:0] lanes;
    bit sof;
    bit eof;
  } beat_t;

  typedef struct {
    int nFrames;
    int gap;
    int readyMode;   // 0 always ready, 1 stalled until inputs done, 2 random
    int partial;     // beats of an aborted frame sent first
    int dropMask;
    int expOvf;
    int expSync;
    int expBeats;
    int expBubbles;  // -1: not checked
  } scen_t;

  beat_t sb[$];
  scen_t tbl[5];

  int checks = 0, errors = 0, prints = 0, cyc = 0;
  int eNeg, vNeg, beats, bubbles, ovfSeen, syncSeen, readyMode;
  bit inStream, tbLast = 1'b0;

  function automatic logic [W-1:0] word(input int tag, input int bin);
    logic [NB-1:0] re;
    re = {tag[7:0], 4'hA, bin[6:0]};
    return {re, ~re};
  endfunction

  function automatic int brev7(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 7; i++) r[i] = v[6-i];
    return r;
  endfunction

  task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (prints < 40) $display("FAIL %s actual=%h required=%h", nm, act, exp);
      prints++;
    end
  endtask

  task automatic monitor();
    beat_t e;
    cyc++;
    if (in_valid && tbLast && eNeg < 0) eNeg = cyc;
    if (ovf) ovfSeen++;
    if (sync_err) syncSeen++;
    if (out_valid) begin
      if (vNeg < 0) vNeg = cyc;
      inStream = 1'b1;
      if (sb.size() == 0) check("unexpected_valid", 1, 0);
      else begin
        e = sb[0];
        check($sformatf("data_b%0d", beats), {o1d, o1u, o0d, o0u}, e.lanes);
        check($sformatf("sof_b%0d", beats), out_sof, e.sof);
        check($sformatf("eof_b%0d", beats), out_eof, e.eof);
        if (out_ready) begin
          void'(sb.pop_front());
          beats++;
        end
      end
    end else if (inStream && sb.size() > 0) bubbles++;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    if (readyMode == 2) out_ready = 1'($urandom_range(0, 1));
    else out_ready = (readyMode == 0);
  endtask

  task automatic clearMon();
    eNeg = -1; vNeg = -1; beats = 0; bubbles = 0;
    ovfSeen = 0; syncSeen = 0; inStream = 1'b0;
  endtask

  task automatic checkZero(input string nm);
    check({nm, "_data"}, {o1d, o1u, o0d, o0u}, '0);
    check({nm, "_ctl"}, {out_valid, out_sof, out_eof, ovf, sync_err}, '0);
`ifdef REORDER_OVF_CNT_EN
    check({nm, "_ovfcnt"}, ovf_cnt, 0);
`endif
  endtask

  task automatic doReset();
    in_valid = 1'b0; in_sof = 1'b0; tbLast = 1'b0;
    rst = 1'b0;
    tick();
    checkZero("reset");
    rst = 1'b1;
    tick();
    tick();
    clearMon();
  endtask

  task automatic pushFrame(input int tag);
    beat_t b;
    for (int k = 0; k < NB4; k++) begin
      for (int m = 0; m < 4; m++) b.lanes[m] = word(tag, k + m*NB4);
      b.sof = (k == 0);
      b.eof = (k == NB4-1);
      sb.push_back(b);
    end
  endtask

  task automatic sendFrame(input int tag, input int nBeats, input bit push);
    if (push) pushFrame(tag);
    for (int c = 0; c < nBeats; c++) begin
      in_valid = 1'b1;
      in_sof   = (c == 0);
      tbLast   = (c == NB4-1);
      in0u = word(tag, brev7(4*c));
      in0d = word(tag, brev7(4*c+1));
      in1u = word(tag, brev7(4*c+2));
      in1d = word(tag, brev7(4*c+3));
      tick();
      if (readyMode == 2 && c < nBeats-1 && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0; in_sof = 1'b0; tbLast = 1'b0;
        tick();
      end
    end
    in_valid = 1'b0; in_sof = 1'b0; tbLast = 1'b0;
  endtask

  task automatic idleBeat(input bit garbage);
    in_valid = garbage; in_sof = 1'b0; tbLast = 1'b0;
    in0u = W'($urandom); in0d = W'($urandom); in1u = W'($urandom); in1d = W'($urandom);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (sb.size() > 0 && n < 4000) begin
      tick();
      n++;
    end
    check({nm, "_drain_left"}, sb.size(), 0);
    repeat (10) tick();
  endtask

  task automatic runScen(input int id);
    scen_t s;
    string nm;
    s = tbl[id];
    nm = $sformatf("s%0d", id);
    readyMode = s.readyMode;
    sb.delete();
    doReset();
    if (s.partial > 0) sendFrame(id*16 + 15, s.partial, 1'b0);
    for (int f = 0; f < s.nFrames; f++) begin
      sendFrame(id*16 + f, NB4, !s.dropMask[f]);
      for (int g = 0; g < s.gap; g++) idleBeat(readyMode == 2);
    end
    if (readyMode == 1) readyMode = 0;
    drain(nm);
    check({nm, "_beats"}, beats, s.expBeats);
    check({nm, "_ovf"}, ovfSeen, s.expOvf);
    check({nm, "_sync"}, syncSeen, s.expSync);
    check({nm, "_latency"}, vNeg - eNeg, 3);
    if (s.expBubbles >= 0) check({nm, "_bubbles"}, bubbles, s.expBubbles);
`ifdef REORDER_OVF_CNT_EN
    check({nm, "_ovfcnt"}, ovf_cnt, s.expOvf);
`endif
  endtask

  initial begin
    int n;
    tbl[0] = '{1, 1,  0, 0,  0, 0, 0, 32,  0};
    tbl[1] = '{3, 1,  0, 0,  0, 0, 0, 96,  2};
    tbl[2] = '{3, 1,  1, 0,  4, 1, 0, 64, -1};
    tbl[3] = '{3, 90, 2, 0,  0, 0, 0, 96, -1};
    tbl[4] = '{1, 1,  0, 10, 0, 0, 1, 32,  0};
    readyMode = 0;
    clearMon();

    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    checkZero("por");
    rst = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) runScen(i);

    // reset while frame 1 is streaming out, then a fresh frame
    readyMode = 0;
    sb.delete();
    doReset();
    sendFrame(8'hE0, NB4, 1'b1);
    n = 0;
    while (beats < 5 && n < 200) begin
      tick();
      n++;
    end
    check("mid_rst_reach_beat5", beats, 5);
    rst = 1'b0;
    sb.delete();
    #1;
    checkZero("mid_rst_a");
    tick();
    checkZero("mid_rst_b");
    rst = 1'b1;
    tick();
    tick();
    clearMon();
    sendFrame(8'hE1, NB4, 1'b1);
    drain("mid_rst");
    check("mid_rst_beats", beats, 32);
    check("mid_rst_ovf", ovfSeen, 0);
    check("mid_rst_sync", syncSeen, 0);
    check("mid_rst_latency", vNeg - eNeg, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
